// File: rtl/mpc_mac_pkg.sv
// Shared types and parameter checks for the pipelined signed MAC.
// Latency: none (types and constants only).
// Backpressure: none; the datapath stalls with a global clock enable.
package mpc_mac_pkg;

  // Tag that travels with every term through the pipeline.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam int MPC_MAC_MAX_MUL_STAGES = 4;

  // Legal parameter set: the accumulator holds a full product, the output
  // fits inside the accumulator, the shift stays within the accumulator
  // and the multiplier depth is in range.
  function automatic bit mpc_mac_params_ok(input int a_w, input int b_w,
                                           input int acc_w, input int out_w,
                                           input int mul_stages, input int shift);
    return (acc_w >= a_w + b_w) && (out_w <= acc_w) && (out_w >= 1) &&
           (mul_stages >= 1) && (mul_stages <= MPC_MAC_MAX_MUL_STAGES) &&
           (shift >= 0) && (shift < acc_w);
  endfunction

endpackage

// File: rtl/mpc_mac_quant.sv
// Output stage: round-half-up arithmetic shift, then saturate (MPC_MAC_SAT_EN) or wrap, registered.
// Latency: 1 enabled cycle from upd to out_valid/p/ovf.
// Backpressure: none; ce=0 freezes the registers, so a pending out_valid is held.
module mpc_mac_quant
  import mpc_mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int OUT_W = 30,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    upd,
  input  logic signed [ACC_W-1:0] acc,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] p,
  output logic                    ovf
);

  // One guard bit keeps the rounding add from overflowing.
  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] y;
  logic signed [OUT_W-1:0] p_d, p_q;
  logic out_valid_d, out_valid_q;

  assign acc_ext = {acc[ACC_W-1], acc};

  if (SHIFT > 0) begin : g_round
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] sum;
    // Add half an LSB of the result, then shift: rounds ties toward +inf.
    always_comb begin
      half = '0;
      half[SHIFT-1] = 1'b1;
      sum = acc_ext + half;
      y = sum >>> SHIFT;
    end
  end else begin : g_noround
    assign y = acc_ext;
  end

`ifdef MPC_MAC_SAT_EN
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  logic ovf_d, ovf_q;

  // Clamp to the representable OUT_W range and flag clipping.
  always_comb begin
    ovf_d = 1'b0;
    p_d   = y[OUT_W-1:0];
    if (y > MAXV) begin
      p_d   = MAXV[OUT_W-1:0];
      ovf_d = 1'b1;
    end else if (y < MINV) begin
      p_d   = MINV[OUT_W-1:0];
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register, loaded together with p.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (ce && upd) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Two's-complement wrap: the high bits of y are simply dropped.
  logic unused_y_hi;
  assign unused_y_hi = ^y[ACC_W:OUT_W];
  assign p_d = y[OUT_W-1:0];
  assign ovf = 1'b0;
`endif

  assign out_valid_d = upd;

  // Result registers: p holds between results, out_valid pulses per result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      out_valid_q <= out_valid_d;
      if (upd) p_q <= p_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/mpc_mac_pipe.sv
// Pipelined signed multiply-accumulate with first/last dot-product tagging; saturation via MPC_MAC_SAT_EN.
// Latency: MUL_STAGES+3 enabled cycles from an in_last term to out_valid; one term per cycle.
// Backpressure: none; ce=0 freezes every register including acc and outputs.
module mpc_mac_pipe
  import mpc_mac_pkg::*;
#(
  parameter int A_W        = 21,
  parameter int B_W        = 9,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 30,
  parameter int SHIFT      = 0,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] p,
  output logic                    ovf
);

  localparam int P_W = A_W + B_W;

  if (!mpc_mac_params_ok(A_W, B_W, ACC_W, OUT_W, MUL_STAGES, SHIFT)) begin : g_param_err
    $error("mpc_mac_pipe: illegal parameter combination");
  end

  logic signed [A_W-1:0] a_d, a_q;
  logic signed [B_W-1:0] b_d, b_q;
  tag_t                  tag0_d, tag0_q;
  logic signed [P_W-1:0] prod_d [MUL_STAGES];
  logic signed [P_W-1:0] prod_q [MUL_STAGES];
  tag_t                  tag_d  [MUL_STAGES];
  tag_t                  tag_q  [MUL_STAGES];
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    upd_d, upd_q;
  tag_t                    tag_m;

  // Input stage: first/last only count when the term is valid.
  always_comb begin
    a_d          = a;
    b_d          = b;
    tag0_d.valid = in_valid;
    tag0_d.first = in_valid & in_first;
    tag0_d.last  = in_valid & in_last;
  end

  // Multiplier pipe: full-precision product in stage 1, then plain delay.
  always_comb begin
    prod_d[0] = a_q * b_q;
    tag_d[0]  = tag0_q;
    for (int i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
  end

  // Accumulate: first reloads, otherwise add with modulo-2^ACC_W wrap.
  always_comb begin
    tag_m    = tag_q[MUL_STAGES-1];
    prod_ext = ACC_W'(prod_q[MUL_STAGES-1]);
    acc_d    = acc_q;
    upd_d    = tag_m.valid & tag_m.last;
    if (tag_m.valid) begin
      acc_d = tag_m.first ? prod_ext : acc_q + prod_ext;
    end
  end

  // Pipeline and accumulator registers; reset wins over ce.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      tag0_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      acc_q  <= '0;
      upd_q  <= 1'b0;
    end else if (ce) begin
      a_q    <= a_d;
      b_q    <= b_d;
      tag0_q <= tag0_d;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_d[i];
        tag_q[i]  <= tag_d[i];
      end
      acc_q  <= acc_d;
      upd_q  <= upd_d;
    end
  end

  mpc_mac_quant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .upd       (upd_q),
    .acc       (acc_q),
    .out_valid (out_valid),
    .p         (p),
    .ovf       (ovf)
  );

endmodule
